// File: rtl/seq_ctrl_ws_pkg.sv
// Shared definitions for the sequence controller: opcode values, FSM state
// encoding and the opcode-class helper.
package seq_ctrl_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_LDA = 3'd3;
    localparam logic [2:0] OP_STO = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_SKZ = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    typedef enum logic [3:0] {
        ST_INST_ADDR  = 4'd0,
        ST_INST_FETCH = 4'd1,
        ST_INST_LOAD  = 4'd2,
        ST_IDLE       = 4'd3,
        ST_OP_ADDR    = 4'd4,
        ST_OP_FETCH   = 4'd5,
        ST_ALU_OP     = 4'd6,
        ST_STORE      = 4'd7,
        ST_HALTED     = 4'd8,
        ST_ERROR      = 4'd9,
        ST_STEP_WAIT  = 4'd10
    } state_t;

    // Operations that read a memory operand into the accumulator.
    function automatic logic is_alu_op(input logic [2:0] opc);
        return (opc == OP_ADD) || (opc == OP_AND) || (opc == OP_XOR) || (opc == OP_LDA);
    endfunction

endpackage

// File: rtl/seq_ctrl_ws_if.sv
// Signal bundle between the sequence controller and the IR/ALU/memory side.
// The step/step_mode pins exist only when SEQ_SINGLE_STEP_EN is defined.
interface seq_ctrl_ws_if #(
    parameter int OPC_W = 3
) ();

    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             mem_ack;
    logic             resume;
    logic             clr_err;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step;
    logic             step_mode;
`endif
    logic             mem_rd;
    logic             mem_wr;
    logic             load_ir;
    logic             load_ac;
    logic             load_pc;
    logic             inc_pc;
    logic             halt;
    logic             bus_err;
    logic             ill_op;
    logic             instr_done;

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
        input  step_mode,
`endif
        input  opcode,
        input  zero,
        input  mem_ack,
        input  resume,
        input  clr_err,
        output mem_rd,
        output mem_wr,
        output load_ir,
        output load_ac,
        output load_pc,
        output inc_pc,
        output halt,
        output bus_err,
        output ill_op,
        output instr_done
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        output step,
        output step_mode,
`endif
        output opcode,
        output zero,
        output mem_ack,
        output resume,
        output clr_err,
        input  mem_rd,
        input  mem_wr,
        input  load_ir,
        input  load_ac,
        input  load_pc,
        input  inc_pc,
        input  halt,
        input  bus_err,
        input  ill_op,
        input  instr_done
    );

endinterface

// File: rtl/seq_ctrl_ws_wait_timer.sv
// Cycle counter for memory wait phases; raises o_expired on the last cycle a
// phase may wait without mem_ack. Collapses to a constant 0 when TIMEOUT is 0.
module seq_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_,
    input  logic i_start,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused  = ^{clk, rst_, i_start, i_active, i_ack};
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_count;

            // Saturates at LAST so the count never wraps inside a phase.
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    r_count <= '0;
                end else if (i_start) begin
                    r_count <= '0;
                end else if (i_active && !i_ack && (r_count != LAST)) begin
                    r_count <= r_count + CW'(1);
                end
            end

            assign o_expired = i_active && !i_ack && (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/seq_ctrl_ws.sv
// Accumulator-CPU sequence controller with memory wait states, timeout, HALTED
// and ERROR states. Define SEQ_SINGLE_STEP_EN to add the single-step pause.
module seq_ctrl_ws #(
    parameter int OPC_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_,
    seq_ctrl_ws_if.master bus
);

    import seq_ctrl_pkg::*;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_bus_err;
    logic       r_ill_op;
    logic       w_bus_err_next;
    logic       w_ill_op_next;
    logic [2:0] w_opc;
    logic       w_alu;
    logic       w_illegal;
    logic       w_wait_now;
    logic       w_wait_next;
    logic       w_expired;
    logic       w_step;
    logic       w_step_mode;

    function automatic logic waits_in(input state_t s, input logic [2:0] opc);
        return (s == ST_INST_FETCH) ||
               ((s == ST_OP_FETCH) && is_alu_op(opc)) ||
               ((s == ST_STORE) && (opc == OP_STO));
    endfunction

    assign w_opc = bus.opcode[2:0];
    assign w_alu = is_alu_op(w_opc);

    generate
        if (OPC_W > 3) begin : g_wide_opc
            assign w_illegal = |bus.opcode[OPC_W-1:3];
        end else begin : g_narrow_opc
            assign w_illegal = 1'b0;
        end
    endgenerate

`ifdef SEQ_SINGLE_STEP_EN
    assign w_step      = bus.step;
    assign w_step_mode = bus.step_mode;
`else
    assign w_step      = 1'b0;
    assign w_step_mode = 1'b0;
`endif

    // No two wait phases are adjacent, so entering one is just a change of class.
    assign w_wait_now  = waits_in(r_state, w_opc);
    assign w_wait_next = waits_in(w_state_next, w_opc);

    seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_      (rst_),
        .i_start   (w_wait_next && !w_wait_now),
        .i_active  (w_wait_now),
        .i_ack     (bus.mem_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state   <= ST_INST_ADDR;
            r_bus_err <= 1'b0;
            r_ill_op  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bus_err <= w_bus_err_next;
            r_ill_op  <= w_ill_op_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bus_err_next = r_bus_err;
        w_ill_op_next  = r_ill_op;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.load_ir    = 1'b0;
        bus.load_ac    = 1'b0;
        bus.load_pc    = 1'b0;
        bus.inc_pc     = 1'b0;
        bus.halt       = 1'b0;
        bus.instr_done = 1'b0;
        bus.bus_err    = r_bus_err;
        bus.ill_op     = r_ill_op;

        case (r_state)
            ST_INST_ADDR: begin
                w_state_next = ST_INST_FETCH;
            end
            ST_INST_FETCH: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ack) begin
                    w_state_next = ST_INST_LOAD;
                end else if (w_expired) begin
                    w_state_next   = ST_ERROR;
                    w_bus_err_next = 1'b1;
                end
            end
            ST_INST_LOAD: begin
                bus.mem_rd   = 1'b1;
                bus.load_ir  = 1'b1;
                w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_illegal) begin
                    w_state_next  = ST_ERROR;
                    w_ill_op_next = 1'b1;
                end else begin
                    w_state_next = ST_OP_ADDR;
                end
            end
            ST_OP_ADDR: begin
                if (w_opc == OP_HLT) begin
                    bus.halt     = 1'b1;
                    w_state_next = ST_HALTED;
                end else begin
                    bus.inc_pc   = 1'b1;
                    w_state_next = ST_OP_FETCH;
                end
            end
            ST_OP_FETCH: begin
                if (w_alu) begin
                    bus.mem_rd = 1'b1;
                    if (bus.mem_ack) begin
                        w_state_next = ST_ALU_OP;
                    end else if (w_expired) begin
                        w_state_next   = ST_ERROR;
                        w_bus_err_next = 1'b1;
                    end
                end else begin
                    w_state_next = ST_ALU_OP;
                end
            end
            ST_ALU_OP: begin
                if (w_alu) begin
                    bus.mem_rd  = 1'b1;
                    bus.load_ac = 1'b1;
                end else if (w_opc == OP_JMP) begin
                    bus.load_pc = 1'b1;
                end else if (w_opc == OP_SKZ) begin
                    bus.inc_pc = bus.zero;
                end
                w_state_next = ST_STORE;
            end
            ST_STORE: begin
                if (w_opc == OP_STO) begin
                    bus.mem_wr = 1'b1;
                    if (!bus.mem_ack && w_expired) begin
                        w_state_next   = ST_ERROR;
                        w_bus_err_next = 1'b1;
                    end
                end
                if ((w_opc != OP_STO) || bus.mem_ack) begin
                    bus.instr_done = 1'b1;
                    w_state_next   = w_step_mode ? ST_STEP_WAIT : ST_INST_ADDR;
                end
            end
            ST_HALTED: begin
                bus.halt = 1'b1;
                if (bus.resume) begin
                    w_state_next = ST_INST_ADDR;
                end
            end
            ST_STEP_WAIT: begin
                bus.halt = 1'b1;
                if (w_step) begin
                    w_state_next = ST_INST_ADDR;
                end
            end
            ST_ERROR: begin
                bus.halt = 1'b1;
                if (bus.clr_err) begin
                    w_state_next   = ST_INST_ADDR;
                    w_bus_err_next = 1'b0;
                    w_ill_op_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_INST_ADDR;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_ctrl_ws.sv
// Self-checking bench for seq_ctrl_ws: per-cycle expected strobe traces are
// built from instruction phase tables and compared against the DUT.
`timescale 1ns/1ps
module tb_seq_ctrl_ws;

    localparam int OPC_W   = 4;
    localparam int TIMEOUT = 16;

    localparam logic [9:0] S_RD   = 10'h200;
    localparam logic [9:0] S_WR   = 10'h100;
    localparam logic [9:0] S_IR   = 10'h080;
    localparam logic [9:0] S_AC   = 10'h040;
    localparam logic [9:0] S_PC   = 10'h020;
    localparam logic [9:0] S_INC  = 10'h010;
    localparam logic [9:0] S_HALT = 10'h008;
    localparam logic [9:0] S_BERR = 10'h004;
    localparam logic [9:0] S_ILL  = 10'h002;
    localparam logic [9:0] S_DONE = 10'h001;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    seq_ctrl_ws_if #(.OPC_W(OPC_W)) bus_if ();

    seq_ctrl_ws #(
        .OPC_W   (OPC_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus_if)
    );

    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic             zero;
        logic             ack;
        logic             res;
        logic             clr;
        logic             stp;
        logic [9:0]       exp;
    } cyc_t;

    cyc_t             trace[$];
    logic [9:0]       obs_q[$];
    logic [OPC_W-1:0] cur_opc;
    logic             cur_zero;
    int               n_checks = 0;
    int               n_fail   = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [9:0] outs();
        return {bus_if.mem_rd, bus_if.mem_wr, bus_if.load_ir, bus_if.load_ac, bus_if.load_pc,
                bus_if.inc_pc, bus_if.halt, bus_if.bus_err, bus_if.ill_op, bus_if.instr_done};
    endfunction

    function automatic int count_obs(input logic [9:0] mask);
        int n = 0;
        foreach (obs_q[i]) if ((obs_q[i] & mask) != 0) n++;
        return n;
    endfunction

    function automatic int first_done();
        foreach (obs_q[i]) if (obs_q[i][0]) return i + 1;
        return -1;
    endfunction

    task automatic push(input logic ack, input logic res, input logic clr, input logic stp,
                        input logic [9:0] exp);
        cyc_t c;
        c.opc = cur_opc; c.zero = cur_zero; c.ack = ack; c.res = res; c.clr = clr;
        c.stp = stp; c.exp = exp;
        trace.push_back(c);
    endtask

    // Expected trace of one complete legal, non-HLT instruction.
    task automatic build_instr(input logic [2:0] opc, input logic z, input int wf, input int wo,
                               input int ws, input logic ack_ones);
        logic [9:0] alu_exp;
        cur_opc  = OPC_W'(opc);
        cur_zero = z;
        push(ack_ones | rb(), rb(), rb(), 1'b0, '0);
        repeat (wf) push(1'b0, rb(), rb(), 1'b0, S_RD);
        push(1'b1, rb(), rb(), 1'b0, S_RD);
        push(ack_ones | rb(), rb(), rb(), 1'b0, S_RD | S_IR);
        push(ack_ones | rb(), rb(), rb(), 1'b0, '0);
        push(ack_ones | rb(), rb(), rb(), 1'b0, S_INC);
        if (opc <= 3'd3) begin
            repeat (wo) push(1'b0, rb(), rb(), 1'b0, S_RD);
            push(1'b1, rb(), rb(), 1'b0, S_RD);
        end else begin
            push(ack_ones | rb(), rb(), rb(), 1'b0, '0);
        end
        case (opc)
            3'd4:    alu_exp = '0;
            3'd5:    alu_exp = S_PC;
            3'd6:    alu_exp = z ? S_INC : 10'h000;
            default: alu_exp = S_RD | S_AC;
        endcase
        push(ack_ones | rb(), rb(), rb(), 1'b0, alu_exp);
        if (opc == 3'd4) begin
            repeat (ws) push(1'b0, rb(), rb(), 1'b0, S_WR);
            push(1'b1, rb(), rb(), 1'b0, S_WR | S_DONE);
        end else begin
            push(ack_ones | rb(), rb(), rb(), 1'b0, S_DONE);
        end
    endtask

    // Drives each trace cycle and records the outputs just before the next edge.
    task automatic play_trace();
        obs_q.delete();
        foreach (trace[i]) begin
            bus_if.opcode  = trace[i].opc;
            bus_if.zero    = trace[i].zero;
            bus_if.mem_ack = trace[i].ack;
            bus_if.resume  = trace[i].res;
            bus_if.clr_err = trace[i].clr;
`ifdef SEQ_SINGLE_STEP_EN
            bus_if.step    = trace[i].stp;
`endif
            #2;
            obs_q.push_back(outs());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [9:0] o;
        #3;
        o = outs();
        n_checks++;
        if (o !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", o, 10'h000);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        o = outs();
        n_checks++;
        if (o !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected %b", o, 10'h000);
        end
        rst_ = 1'b1;
        $display("reset: outputs checked while held");
    endtask

    task automatic test_lda();
        int d;
        trace.delete();
        build_instr(3'd3, rb(), 0, 0, 0, 1'b1);
        play_trace();
        foreach (trace[i]) begin
            n_checks++;
            if (obs_q[i] !== trace[i].exp) begin
                n_fail++;
                $display("FAIL lda cycle %0d: got %b expected %b", i, obs_q[i], trace[i].exp);
            end
        end
        d = first_done();
        n_checks++;
        if (d !== 8) begin
            n_fail++;
            $display("FAIL lda_length: got %0d expected %0d", d, 8);
        end
        $display("lda: %0d cycles", d);
    endtask

    task automatic test_sto_wait();
        int d, w;
        trace.delete();
        build_instr(3'd4, rb(), 0, 0, 3, 1'b0);
        play_trace();
        foreach (trace[i]) begin
            n_checks++;
            if (obs_q[i] !== trace[i].exp) begin
                n_fail++;
                $display("FAIL sto_wait cycle %0d: got %b expected %b", i, obs_q[i], trace[i].exp);
            end
        end
        d = first_done();
        w = count_obs(S_WR);
        n_checks++;
        if (d !== 11 || w !== 4) begin
            n_fail++;
            $display("FAIL sto_wait_len: got len %0d wr %0d expected len 11 wr 4", d, w);
        end
        $display("sto_wait: %0d cycles, mem_wr %0d cycles", d, w);
    endtask

    task automatic test_skz_jmp();
        logic [2:0] opcs[3] = '{3'd6, 3'd6, 3'd5};
        logic       zs[3]   = '{1'b1, 1'b0, 1'b0};
        int         want[3] = '{2, 1, 1};
        int         got;
        for (int k = 0; k < 3; k++) begin
            trace.delete();
            build_instr(opcs[k], zs[k], $urandom_range(0, 3), 0, 0, 1'b0);
            play_trace();
            foreach (trace[i]) begin
                n_checks++;
                if (obs_q[i] !== trace[i].exp) begin
                    n_fail++;
                    $display("FAIL skz_jmp_%0d cycle %0d: got %b expected %b", k, i, obs_q[i],
                             trace[i].exp);
                end
            end
            got = (opcs[k] == 3'd5) ? count_obs(S_PC) : count_obs(S_INC);
            n_checks++;
            if (got !== want[k]) begin
                n_fail++;
                $display("FAIL skz_jmp_pulses_%0d: got %0d expected %0d", k, got, want[k]);
            end
            $display("skz_jmp: opc %0d zero %0b pulses %0d", opcs[k], zs[k], got);
        end
    endtask

    task automatic test_wait_boundary();
        trace.delete();
        build_instr(3'd0, rb(), TIMEOUT - 1, TIMEOUT - 1, 0, 1'b0);
        build_instr(3'd4, rb(), 0, 0, TIMEOUT - 1, 1'b0);
        play_trace();
        foreach (trace[i]) begin
            n_checks++;
            if (obs_q[i] !== trace[i].exp) begin
                n_fail++;
                $display("FAIL wait_boundary cycle %0d: got %b expected %b", i, obs_q[i],
                         trace[i].exp);
            end
        end
        $display("wait_boundary: ack on last allowed wait cycle, %0d cycles", trace.size());
    endtask

    task automatic test_timeout();
        trace.delete();
        cur_opc  = OPC_W'(3);
        cur_zero = 1'b0;
        push(rb(), rb(), rb(), 1'b0, '0);
        repeat (TIMEOUT) push(1'b0, rb(), rb(), 1'b0, S_RD);
        repeat (3) push(rb(), rb(), 1'b0, 1'b0, S_HALT | S_BERR);
        push(rb(), rb(), 1'b1, 1'b0, S_HALT | S_BERR);
        build_instr(3'd1, rb(), 1, 1, 0, 1'b0);
        play_trace();
        foreach (trace[i]) begin
            n_checks++;
            if (obs_q[i] !== trace[i].exp) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: got %b expected %b", i, obs_q[i], trace[i].exp);
            end
        end
        $display("timeout: fetch timeout, clr_err, recovery instruction");
    endtask

    task automatic test_halt();
        trace.delete();
        cur_opc  = OPC_W'(7);
        cur_zero = rb();
        push(rb(), rb(), rb(), 1'b0, '0);
        push(1'b1, rb(), rb(), 1'b0, S_RD);
        push(rb(), rb(), rb(), 1'b0, S_RD | S_IR);
        push(rb(), rb(), rb(), 1'b0, '0);
        push(rb(), 1'b0, rb(), 1'b0, S_HALT);
        repeat (20) push(rb(), 1'b0, rb(), 1'b0, S_HALT);
        push(rb(), 1'b1, rb(), 1'b0, S_HALT);
        build_instr(3'($urandom_range(0, 6)), rb(), 0, 0, 0, 1'b0);
        play_trace();
        foreach (trace[i]) begin
            n_checks++;
            if (obs_q[i] !== trace[i].exp) begin
                n_fail++;
                $display("FAIL halt cycle %0d: got %b expected %b", i, obs_q[i], trace[i].exp);
            end
        end
        $display("halt: 20 halted cycles then resume");
    endtask

    task automatic test_illegal();
        logic [OPC_W-1:0] bad[2] = '{4'b1000, 4'b1111};
        for (int k = 0; k < 2; k++) begin
            trace.delete();
            cur_opc  = bad[k];
            cur_zero = rb();
            push(rb(), rb(), rb(), 1'b0, '0);
            push(1'b1, rb(), rb(), 1'b0, S_RD);
            push(rb(), rb(), rb(), 1'b0, S_RD | S_IR);
            push(rb(), rb(), rb(), 1'b0, '0);
            repeat (4) push(rb(), rb(), 1'b0, 1'b0, S_HALT | S_ILL);
            push(rb(), rb(), 1'b1, 1'b0, S_HALT | S_ILL);
            build_instr(3'd2, rb(), 0, 2, 0, 1'b0);
            play_trace();
            foreach (trace[i]) begin
                n_checks++;
                if (obs_q[i] !== trace[i].exp) begin
                    n_fail++;
                    $display("FAIL illegal_%0d cycle %0d: got %b expected %b", k, i, obs_q[i],
                             trace[i].exp);
                end
            end
            $display("illegal: opcode %b trapped and cleared", bad[k]);
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] o;
        trace.delete();
        cur_opc  = OPC_W'(3);
        cur_zero = 1'b0;
        push(rb(), rb(), rb(), 1'b0, '0);
        repeat (3) push(1'b0, rb(), rb(), 1'b0, S_RD);
        play_trace();
        foreach (trace[i]) begin
            n_checks++;
            if (obs_q[i] !== trace[i].exp) begin
                n_fail++;
                $display("FAIL async_pre cycle %0d: got %b expected %b", i, obs_q[i], trace[i].exp);
            end
        end
        bus_if.mem_ack = 1'b0;
        #2;
        o = outs();
        n_checks++;
        if (o !== S_RD) begin
            n_fail++;
            $display("FAIL async_mid_wait: got %b expected %b", o, S_RD);
        end
        rst_ = 1'b0;
        #1;
        o = outs();
        n_checks++;
        if (o !== 10'h000) begin
            n_fail++;
            $display("FAIL async_drop: got %b expected %b", o, 10'h000);
        end
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        trace.delete();
        build_instr(3'd3, rb(), 0, 0, 0, 1'b1);
        play_trace();
        foreach (trace[i]) begin
            n_checks++;
            if (obs_q[i] !== trace[i].exp) begin
                n_fail++;
                $display("FAIL async_post cycle %0d: got %b expected %b", i, obs_q[i],
                         trace[i].exp);
            end
        end
        $display("async_reset: strobes dropped mid-wait, restart from INST_ADDR");
    endtask

    task automatic test_random();
        logic [2:0] opc;
        for (int n = 0; n < 25; n++) begin
            trace.delete();
            opc = 3'($urandom_range(0, 6));
            build_instr(opc, rb(), $urandom_range(0, 6), $urandom_range(0, 6),
                        $urandom_range(0, 6), 1'b0);
            play_trace();
            foreach (trace[i]) begin
                n_checks++;
                if (obs_q[i] !== trace[i].exp) begin
                    n_fail++;
                    $display("FAIL random_%0d cycle %0d: got %b expected %b", n, i, obs_q[i],
                             trace[i].exp);
                end
            end
            $display("random: instr %0d opc %0d, %0d cycles", n, opc, trace.size());
        end
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        bus_if.step_mode = 1'b1;
        trace.delete();
        build_instr(3'd0, rb(), 0, 0, 0, 1'b0);
        repeat (5) push(rb(), 1'b1, rb(), 1'b0, S_HALT);
        push(rb(), rb(), rb(), 1'b1, S_HALT);
        play_trace();
        foreach (trace[i]) begin
            n_checks++;
            if (obs_q[i] !== trace[i].exp) begin
                n_fail++;
                $display("FAIL single_step cycle %0d: got %b expected %b", i, obs_q[i],
                         trace[i].exp);
            end
        end
        bus_if.step_mode = 1'b0;
        trace.delete();
        build_instr(3'd3, rb(), 0, 0, 0, 1'b1);
        play_trace();
        foreach (trace[i]) begin
            n_checks++;
            if (obs_q[i] !== trace[i].exp) begin
                n_fail++;
                $display("FAIL single_step_after cycle %0d: got %b expected %b", i, obs_q[i],
                         trace[i].exp);
            end
        end
        $display("single_step: STEP_WAIT held until step");
    endtask
`endif

    initial begin
        bus_if.opcode  = '0;
        bus_if.zero    = 1'b0;
        bus_if.mem_ack = 1'b0;
        bus_if.resume  = 1'b0;
        bus_if.clr_err = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        bus_if.step      = 1'b0;
        bus_if.step_mode = 1'b0;
`endif
        test_reset();
        test_lda();
        test_sto_wait();
        test_skz_jmp();
        test_wait_boundary();
        test_timeout();
        test_halt();
        test_illegal();
        test_async_reset();
        test_random();
`ifdef SEQ_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_ctrl_ws.md
Name: seq_ctrl_ws

Overview:
Next-generation sequence controller for the accumulator CPU.
- Adds memory wait-state handshake with timeout, a persistent HALTED state with resume, and illegal-opcode trapping.
- Opcode width is parametrised.
- Sits between the instruction register/ALU zero flag and the PC, AC, IR and memory bus strobes.

Parameters:
OPC_W, 3, opcode width (>=3). The low 3 bits select the operation; any nonzero upper bit is illegal.
TIMEOUT, 16, maximum cycles waiting for mem_ack in a memory phase. 0 disables the timeout.

Ports:
clk  in  1  clock
rst_  in  1  reset, asynchronous, active-low
opcode  in  OPC_W  opcode from IR; stable from IDLE through STORE
zero  in  1  accumulator-zero flag, sampled in ALU_OP
mem_ack  in  1  memory completes the current rd/wr at this posedge
resume  in  1  leave HALTED (level, sampled)
clr_err  in  1  leave ERROR (level, sampled)
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
load_ir  out  1  latch instruction register
load_ac  out  1  latch accumulator
load_pc  out  1  load PC from IR operand
inc_pc  out  1  increment PC
halt  out  1  controller halted
bus_err  out  1  memory timeout occurred
ill_op  out  1  illegal opcode trapped
instr_done  out  1  one-cycle pulse on the last cycle of each instruction (STORE exit)

Behaviour:
- General
  - Clock and reset: rising edge of clk; reset rst_, asynchronous, active-low.
  - Reset state: INST_ADDR; wait counter 0; bus_err and ill_op cleared.
  - Outputs at reset: all outputs 0.
  - Output decode: all strobes are combinational from state, opcode, zero, mem_ack and resume.
  - Opcodes: ADD=0, AND=1, XOR=2, LDA=3, STO=4, JMP=5, SKZ=6, HLT=7. ALU-class = ADD/AND/XOR/LDA.
- State transitions and strobes
  - INST_ADDR: -> INST_FETCH. No strobes.
  - INST_FETCH: mem_rd=1. Stays until mem_ack=1, then -> INST_LOAD.
  - INST_LOAD: mem_rd=1, load_ir=1. -> IDLE.
  - IDLE: if opcode upper bits are nonzero -> ERROR with ill_op set; else -> OP_ADDR.
  - OP_ADDR:
    - HLT: halt=1, -> HALTED.
    - Otherwise: inc_pc=1, -> OP_FETCH.
  - OP_FETCH:
    - ALU-class: mem_rd=1; waits for mem_ack.
    - Other opcodes: pass in 1 cycle. -> ALU_OP.
  - ALU_OP:
    - ALU-class: mem_rd=1, load_ac=1.
    - JMP: load_pc=1.
    - SKZ: inc_pc=zero.
    - STO: no strobe.
    - -> STORE.
  - STORE:
    - STO: mem_wr=1; waits for mem_ack.
    - Other opcodes: 1 cycle.
    - On exit: instr_done=1, -> INST_ADDR.
  - HALTED: halt=1.
    - resume=1: -> INST_ADDR. No inc_pc (PC was not incremented past HLT).
    - Otherwise: stay.
  - ERROR: halt=1; no strobes. clr_err=1: -> INST_ADDR, with bus_err and ill_op cleared on that edge.
- Wait and timeout
  - Counter clears on entry to each wait phase and increments every waiting cycle.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with mem_ack=0: -> ERROR, bus_err set.
  - mem_ack in that same cycle wins over the timeout.
  - Minimum instruction length with zero wait: 8 cycles. Each wait cycle adds 1.
  - mem_ack outside a wait phase is ignored.
- Encoding and reset: state enum 4 bits. Reset mid-wait returns to INST_ADDR immediately; strobes drop asynchronously.

Optional Feature:
SEQ_SINGLE_STEP_EN
- When defined:
  - Adds input step (1 bit) and input step_mode (1 bit).
  - With step_mode=1, the STORE exit goes to STEP_WAIT (halt=1) instead of INST_ADDR.
  - STEP_WAIT -> INST_ADDR when step=1.
  - resume is ignored in STEP_WAIT.
- When undefined: ports are absent and STORE always -> INST_ADDR.

Decomposition:
- Package seq_ctrl_pkg holds:
  - opcode localparams (3-bit);
  - state_t enum;
  - function is_alu_op(logic [2:0]).
- One sub-module, seq_wait_timer: the wait counter, with inputs start/active/ack and output expired. It is a no-op when TIMEOUT=0.

Test Plan:
1. LDA with mem_ack tied 1 -> 8-cycle instruction; mem_rd in INST_FETCH, INST_LOAD, OP_FETCH, ALU_OP; load_ac=1 in ALU_OP; instr_done at cycle 8.
2. STO with mem_ack delayed 3 cycles in STORE -> mem_wr held 4 cycles; instruction takes 11 cycles; no bus_err.
3. TIMEOUT=16, mem_ack held 0 in INST_FETCH -> ERROR after 16 fetch cycles, bus_err=1, halt=1; then clr_err=1 -> INST_ADDR with bus_err=0.
4. SKZ with zero=1 -> inc_pc pulses in OP_ADDR and ALU_OP (2 total). With zero=0 -> 1 pulse. JMP -> load_pc=1 only in ALU_OP.
5. HLT -> halt=1 from OP_ADDR, no inc_pc, stays HALTED 20 cycles; resume=1 -> next state INST_ADDR. OPC_W=4 with opcode 4'b1000 -> ERROR, ill_op=1.
6. Reset asserted mid INST_FETCH wait -> all strobes 0 asynchronously; after release, next cycle INST_ADDR. Under SEQ_SINGLE_STEP_EN with step_mode=1 -> STEP_WAIT after STORE, advances only on step=1.
